posit_fault_monitor: RTL
========================

// Module: posit_fault_monitor
// PURPOSE
//  Sits downstream of the posit truncated-adder fault checker; samples its per-op result (fault, mode, sums, scales)
//  when in_valid=1, keeps saturating op/fault/trunc-mode statistics, buffers faulting ops in a FIFO drained by a
//  valid/ready consumer, and raises a sticky alarm when faults within a sliding op window reach a threshold.
// PARAMETERS
//  N            32  posit width of in_true_sum/in_used_sum
//  DEPTH        4   fault-record FIFO entries (power of 2, >=2)
//  CNT_W        16  width of statistic counters and sequence number
//  WINDOW       16  ops per alarm window (>=2)
//  ALARM_THRESH 3   faults within one window that trigger alarm (1..WINDOW)
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  clear          in   1      sync clear: counters, FIFO, window, alarm
//  in_valid       in   1      checker output valid this cycle (no backpressure)
//  in_fault       in   1      checker fault flag
//  in_mode        in   1      1 = truncated adder used
//  in_true_sum    in   N      full-width sum
//  in_used_sum    in   N      checker sum (zero-extended when mode=1)
//  in_true_scale  in   7      scale of true sum
//  in_used_scale  in   7      scale of used sum
//  evt_valid      out  1      fault record at FIFO head
//  evt_ready      in   1      consumer pops when evt_valid&evt_ready
//  evt_seq        out  CNT_W  op_count value of the faulting op
//  evt_mode       out  1      mode of faulting op
//  evt_true_sum   out  N      true sum of faulting op
//  evt_used_sum   out  N      used sum of faulting op
//  op_count       out  CNT_W  accepted ops, saturating
//  fault_count    out  CNT_W  faults, saturating
//  trunc_count    out  CNT_W  ops with mode=1, saturating
//  drop_count     out  CNT_W  faults lost to a full FIFO, saturating
//  fifo_full      out  1      FIFO holds DEPTH records
//  alarm          out  1      sticky window alarm
// BEHAVIOUR
//  - Reset: every output 0 (evt_* payload 0); FIFO empty; window count/faults 0; FSM MONITOR.
//  - Accept: sample taken each edge with in_valid=1; counters visible 1 cycle later; all saturate at 2^CNT_W-1.
//  - evt_seq = op_count value before increment (first op has seq 0).
//  - Push on accepted in_fault=1; record visible on evt_* 1 cycle after accept (registered head, FWFT).
//  - Push when full: allowed only if a pop occurs the same cycle; otherwise record dropped, drop_count+1.
//  - Push+pop when empty: no bypass; evt_valid rises the next cycle. evt_* stable while evt_valid&!evt_ready.
//  - Window: win_cnt 0..WINDOW-1 advances per accepted op, wraps to 0; win_faults resets at wrap and
//    counts only ops of the new window.
//  - FSM MONITOR->ALARMED on the accept at which win_faults incl. current op reaches ALARM_THRESH;
//    alarm=1 from next cycle. ALARMED: window logic frozen, stats and FIFO keep running.
//  - clear (any state): next cycle all counters 0, FIFO flushed, evt_valid 0, alarm 0, FSM MONITOR;
//    a sample or pop in the clear cycle is discarded/ignored. clear wins over everything except rst_n.
//  - rst_n low mid-operation: immediate return to reset values, including FIFO contents.
// CONFIGURATION
//  FAULT_MON_SCALE_DELTA_EN defined: adds out port max_scale_delta[6:0] = largest |true_scale-used_scale| seen
//  (reset/clear 0, updated 1 cycle after accept, all ops), and each record carries evt_scale_delta[6:0].
//  Undefined: ports absent, FIFO width N*2+CNT_W+1, scale inputs ignored.
// STRUCTURE
//  - Shared package posit_fault_pkg: FSM state encoding (MONITOR, ALARMED), record field widths/offsets,
//    saturating-increment function.
//  - Sub-module fault_event_fifo (parameterised width/depth, FWFT, full/empty, sync flush); the rest stays here.
// TESTING
//  1. 10 ops in_fault=0, in_mode=1 -> op_count=10, trunc_count=10, fault_count=0, evt_valid=0, alarm=0.
//  2. op#2 fault, true_sum=0x40000000, used_sum=0x00004000, evt_ready=0 -> evt_valid=1, evt_seq=2, payload held
//     until evt_ready=1, then evt_valid=0 next cycle.
//  3. DEPTH=4, evt_ready=0, 6 consecutive faults -> fifo_full=1, drop_count=2; one pop+fault same cycle -> drop_count stays 2.
//  4. WINDOW=16, THRESH=3: faults at ops 1,3,5 -> alarm=1 cycle after op 5; remains 1 until clear.
//  5. Faults at ops 14,15 then 16,17 (window wrap) -> alarm stays 0, fault_count=4.
//  6. rst_n low while FIFO holds 3 records -> all outputs 0 immediately; clear with in_valid=1 -> op_count stays 0.

Source files
------------

// File: rtl/posit_fault_pkg.sv
// Shared definitions for the posit fault monitor: FSM encoding, fault-record layout and saturating increment.
package posit_fault_pkg;

    localparam logic [0:0] MONITOR = 1'b0;
    localparam logic [0:0] ALARMED = 1'b1;

    localparam int SCALE_W = 7;

    // Record layout, LSB first: true_sum, used_sum, seq, mode[, scale_delta]
    function automatic int rec_used_lsb(input int n);
        return n;
    endfunction

    function automatic int rec_seq_lsb(input int n);
        return 2 * n;
    endfunction

    function automatic int rec_mode_bit(input int n, input int cw);
        return 2 * n + cw;
    endfunction

    function automatic int rec_delta_lsb(input int n, input int cw);
        return 2 * n + cw + 1;
    endfunction

    function automatic int rec_width(input int n, input int cw);
`ifdef FAULT_MON_SCALE_DELTA_EN
        return 2 * n + cw + 1 + SCALE_W;
`else
        return 2 * n + cw + 1;
`endif
    endfunction

    // Counters up to 32 bits share this; the caller narrows the result back to its width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] maxv;
        maxv = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v == maxv) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fault_event_fifo.sv
// First-word-fall-through record FIFO with synchronous flush; a push into a full FIFO succeeds only alongside a pop.
module fault_event_fifo #(
    parameter int W     = 81,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/posit_fault_monitor.sv
// Statistics, fault-record buffering and sliding-window alarm for the posit truncated-adder checker.
// Optional FAULT_MON_SCALE_DELTA_EN adds max_scale_delta and a per-record evt_scale_delta.
module posit_fault_monitor
    import posit_fault_pkg::*;
#(
    parameter int N            = 32,
    parameter int DEPTH        = 4,
    parameter int CNT_W        = 16,
    parameter int WINDOW       = 16,
    parameter int ALARM_THRESH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    input  logic               in_fault,
    input  logic               in_mode,
    input  logic [N-1:0]       in_true_sum,
    input  logic [N-1:0]       in_used_sum,
    input  logic [SCALE_W-1:0] in_true_scale,
    input  logic [SCALE_W-1:0] in_used_scale,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [CNT_W-1:0]   evt_seq,
    output logic               evt_mode,
    output logic [N-1:0]       evt_true_sum,
    output logic [N-1:0]       evt_used_sum,
    output logic [CNT_W-1:0]   op_count,
    output logic [CNT_W-1:0]   fault_count,
    output logic [CNT_W-1:0]   trunc_count,
    output logic [CNT_W-1:0]   drop_count,
    output logic               fifo_full,
    output logic               alarm
`ifdef FAULT_MON_SCALE_DELTA_EN
    ,
    output logic [SCALE_W-1:0] max_scale_delta,
    output logic [SCALE_W-1:0] evt_scale_delta
`endif
);

    localparam int REC_W     = rec_width(N, CNT_W);
    localparam int USED_LSB  = rec_used_lsb(N);
    localparam int SEQ_LSB   = rec_seq_lsb(N);
    localparam int MODE_BIT  = rec_mode_bit(N, CNT_W);
    localparam int WIN_W     = $clog2(WINDOW);
    localparam int WF_W      = $clog2(WINDOW + 1);

    logic             accept;
    logic             pop;
    logic             push;
    logic             drop;
    logic [REC_W-1:0] rec_in;
    logic [REC_W-1:0] rec_out;
    logic [0:0]       state;
    logic [WIN_W-1:0] win_cnt;
    logic [WF_W-1:0]  win_faults;
    logic [WF_W-1:0]  win_faults_nxt;

    // clear swallows both the sample and the pop of its own cycle
    assign accept         = in_valid && !clear;
    assign pop            = evt_valid && evt_ready && !clear;
    assign push           = accept && in_fault;
    assign drop           = push && fifo_full && !pop;
    assign win_faults_nxt = win_faults + WF_W'(in_fault);
    assign alarm          = (state == ALARMED);

`ifdef FAULT_MON_SCALE_DELTA_EN
    localparam int DELTA_LSB = rec_delta_lsb(N, CNT_W);
    logic signed [SCALE_W:0] sd_diff;
    logic [SCALE_W-1:0]      sd_abs;

    // Scales are two's complement, so the magnitude of the difference fits in SCALE_W bits
    assign sd_diff = $signed({in_true_scale[SCALE_W-1], in_true_scale})
                   - $signed({in_used_scale[SCALE_W-1], in_used_scale});
    assign sd_abs  = sd_diff[SCALE_W] ? SCALE_W'(-sd_diff) : sd_diff[SCALE_W-1:0];
    assign evt_scale_delta = rec_out[DELTA_LSB +: SCALE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_scale_delta <= '0;
        end else if (clear) begin
            max_scale_delta <= '0;
        end else if (accept && (sd_abs > max_scale_delta)) begin
            max_scale_delta <= sd_abs;
        end
    end
`else
    logic unused_scale;
    assign unused_scale = ^{in_true_scale, in_used_scale};
`endif

    always_comb begin
        rec_in                        = '0;
        rec_in[N-1:0]                 = in_true_sum;
        rec_in[USED_LSB +: N]         = in_used_sum;
        rec_in[SEQ_LSB +: CNT_W]      = op_count;
        rec_in[MODE_BIT]              = in_mode;
`ifdef FAULT_MON_SCALE_DELTA_EN
        rec_in[DELTA_LSB +: SCALE_W]  = sd_abs;
`endif
    end

    fault_event_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clear),
        .push  (push),
        .pop   (pop),
        .din   (rec_in),
        .dout  (rec_out),
        .valid (evt_valid),
        .full  (fifo_full)
    );

    assign evt_true_sum = rec_out[N-1:0];
    assign evt_used_sum = rec_out[USED_LSB +: N];
    assign evt_seq      = rec_out[SEQ_LSB +: CNT_W];
    assign evt_mode     = rec_out[MODE_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count    <= '0;
            fault_count <= '0;
            trunc_count <= '0;
            drop_count  <= '0;
        end else if (clear) begin
            op_count    <= '0;
            fault_count <= '0;
            trunc_count <= '0;
            drop_count  <= '0;
        end else begin
            if (accept) op_count <= CNT_W'(sat_inc(32'(op_count), CNT_W));
            if (push) fault_count <= CNT_W'(sat_inc(32'(fault_count), CNT_W));
            if (accept && in_mode) trunc_count <= CNT_W'(sat_inc(32'(trunc_count), CNT_W));
            if (drop) drop_count <= CNT_W'(sat_inc(32'(drop_count), CNT_W));
        end
    end

    // Window bookkeeping runs only while monitoring; once alarmed it stays frozen until clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MONITOR;
            win_cnt    <= '0;
            win_faults <= '0;
        end else if (clear) begin
            state      <= MONITOR;
            win_cnt    <= '0;
            win_faults <= '0;
        end else if (accept && (state == MONITOR)) begin
            if (win_faults_nxt >= WF_W'(ALARM_THRESH)) state <= ALARMED;
            if (win_cnt == WIN_W'(WINDOW - 1)) begin
                win_cnt    <= '0;
                win_faults <= '0;
            end else begin
                win_cnt    <= win_cnt + WIN_W'(1);
                win_faults <= win_faults_nxt;
            end
        end
    end

endmodule
